irq_arbiter: RTL and testbench
==============================

Name: irq_arbiter

Overview:
- Machine-mode interrupt arbiter between the CLINT/external interrupt sources and the core's trap/CSR unit.
- Samples the timer (o_tip of the CLINT), software and external interrupt lines, and maintains the mip pending image.
- Applies mie/mstatus.MIE gating and selects one cause by RISC-V priority (MEI > MSI > MTI).
- Presents the selected cause to the trap unit over a req/ack handshake and produces a WFI wake signal.

Parameters:
- SYNC_STAGES, 2, flop depth of the synchronizer on the asynchronous external interrupt line (legal 2..4).
- HOLD_CYCLES, 1, cycles spent in HOLD after an ack, so that trap entry can clear mstatus.MIE (legal 1..7).

Ports:
- i_clk  in  1  core clock.
- i_rst  in  1  asynchronous, active-high reset.
- i_tip  in  1  machine timer interrupt from CLINT, synchronous to i_clk.
- i_sip  in  1  machine software interrupt (msip), synchronous to i_clk.
- i_eip  in  1  machine external interrupt, asynchronous.
- i_mie  in  `XLEN  mie CSR value; only bits 11, 7 and 3 are used.
- i_mstatus_mie  in  1  global machine interrupt enable.
- i_irq_ack  in  1  trap unit accepts the current request.
- o_irq_req  out  1  interrupt trap request.
- o_irq_cause  out  `XLEN  mcause value; MSB=1, low bits=11/3/7.
- o_mip  out  `XLEN  pending image for mip CSR reads; bits 11, 7 and 3 are live, all others 0.
- o_wfi_wake  out  1  some enabled interrupt is pending, independent of mstatus.MIE.

Behaviour:
- Reset:
  - Asynchronous on i_rst=1; all flops cleared.
  - o_irq_req=0, o_irq_cause=0, o_mip=0, o_wfi_wake=0, state=IDLE, synchronizer chain=0.
- Pending capture:
  - p_mti <= i_tip; p_msi <= i_sip (1-cycle latency).
  - p_mei is the output of a SYNC_STAGES-deep synchronizer.
  - All levels are sensitive; none are latched. o_mip = {p_mei@11, p_mti@7, p_msi@3}.
- Enabled set: en = mip & i_mie restricted to bits 11/7/3.
- Wake: o_wfi_wake is registered from (|en); 1-cycle latency after pending.
- Priority select (combinational): MEI(11) over MSI(3) over MTI(7). sel_cause = {1'b1, zero-extended code}.
- FSM states IDLE, REQ, HOLD:
  - IDLE: if (|en) && i_mstatus_mie, then next cycle o_irq_req=1, o_irq_cause=sel_cause, and go to REQ.
  - REQ, cause stability: o_irq_cause is frozen while in REQ. No preemption by higher-priority arrivals.
  - REQ, on i_irq_ack=1: go to HOLD; o_irq_req=0 next cycle.
  - REQ, withdraw: with no ack and the frozen cause no longer in en, or i_mstatus_mie=0, go to IDLE; req=0 next cycle, cause retained but don't-care.
  - REQ, ack and withdraw in the same cycle: ack wins, go to HOLD.
  - HOLD: down-counter loaded with HOLD_CYCLES; req=0. Return to IDLE when the count reaches 0. Re-arbitration happens only in IDLE.
  - i_irq_ack while not in REQ is ignored.
- Latency:
  - i_tip rising sampled at edge k: o_mip[7] set at k+1, o_irq_req set at k+2 (if enabled).
  - i_eip: o_mip[11] set at edge k+SYNC_STAGES, req at k+SYNC_STAGES+1.
- Mid-operation reset: immediate return to reset values; an outstanding request is dropped, with no ack required.
- Width: cause code occupies bits [3:0]; bits [`XLEN-2:4] are 0; MSB=1.

Decomposition:
- Shared package/defines.vh:
  - IRQ bit indices MEI_BIT=11, MTI_BIT=7, MSI_BIT=3.
  - Cause codes and CAUSE_INT_MSB.
  - FSM state encoding localparams (IDLE=0, REQ=1, HOLD=2).
- One sub-module: sync_ff, a parameterised N-stage synchronizer (async active-high reset to 0), reused for i_eip.

Test Plan:
1. Reset, then i_mie=0x888, i_mstatus_mie=1, i_tip 0→1 at cycle 10 -> o_mip=0x080 at 11; o_irq_req=1, cause=0x80000007 at 12; ack at 14 -> req=0 at 15; HOLD 1 cycle.
2. Simultaneous i_tip=i_sip=1 and i_eip=1 (SYNC_STAGES=2) -> first req cause 0x80000003 (MSI ahead of sync'd MEI); after ack+HOLD, next req 0x8000000B.
3. In REQ with cause 7, i_eip rises -> cause stays 0x80000007 until ack; no glitch on o_irq_cause.
4. In REQ, drop i_tip with no ack -> req=0 next cycle, FSM IDLE; ack+drop in same cycle -> HOLD, trap taken with cause 7.
5. i_mstatus_mie=0, i_mie=0x080, i_tip=1 -> o_irq_req stays 0, o_wfi_wake=1 one cycle after o_mip[7].
6. Assert i_rst asynchronously mid-REQ (between edges) -> o_irq_req, o_mip, o_wfi_wake go 0 immediately; after release with i_tip still 1, req reasserts 2 cycles later.

Source files
------------

// File: rtl/irq_arbiter_pkg.sv
// Shared constants for the machine-mode interrupt arbiter: mip bit positions, mcause codes,
// FSM state encoding and a helper that builds an interrupt mcause value.
package irq_arbiter_pkg;

  localparam int unsigned XLEN = 32;

  localparam int unsigned MEI_BIT = 11;
  localparam int unsigned MTI_BIT = 7;
  localparam int unsigned MSI_BIT = 3;

  localparam logic [3:0] CAUSE_MEI = 4'd11;
  localparam logic [3:0] CAUSE_MTI = 4'd7;
  localparam logic [3:0] CAUSE_MSI = 4'd3;

  localparam int unsigned CAUSE_INT_MSB = XLEN - 1;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StHold = 2'd2
  } arb_state_e;

  function automatic logic [XLEN-1:0] mk_cause(input logic [3:0] code);
    logic [XLEN-1:0] c;
    c                = '0;
    c[CAUSE_INT_MSB] = 1'b1;
    c[3:0]           = code;
    return c;
  endfunction

endpackage

// File: rtl/irq_arbiter_if.sv
// Trap/CSR-side bundle of the interrupt arbiter. The arbiter uses the master modport and the
// trap unit the slave modport.
interface irq_arbiter_if;
  import irq_arbiter_pkg::*;

  logic            irq_req;
  logic            irq_ack;
  logic [XLEN-1:0] irq_cause;
  logic [XLEN-1:0] mie;
  logic            mstatus_mie;
  logic [XLEN-1:0] mip;
  logic            wfi_wake;

  modport master (
    output irq_req, irq_cause, mip, wfi_wake,
    input  irq_ack, mie, mstatus_mie
  );

  modport slave (
    input  irq_req, irq_cause, mip, wfi_wake,
    output irq_ack, mie, mstatus_mie
  );

endinterface

// File: rtl/irq_arbiter_sync_ff.sv
// N-stage flop synchronizer for a single asynchronous level, cleared by an async active-high
// reset.
module irq_arbiter_sync_ff #(
  parameter int unsigned Stages = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [Stages-1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[Stages-2:0], d_i};
    end
  end

  assign q_o = sync_q[Stages-1];

endmodule

// File: rtl/irq_arbiter.sv
// Machine-mode interrupt arbiter: builds the mip image, gates it with mie/mstatus.MIE, picks one
// cause (MEI > MSI > MTI) and hands it to the trap unit over a req/ack handshake.
module irq_arbiter
  import irq_arbiter_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned HOLD_CYCLES = 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_tip,
  input  logic          i_sip,
  input  logic          i_eip,
  irq_arbiter_if.master bus
);

  localparam logic [2:0] HoldLoad = 3'(HOLD_CYCLES);

  logic            p_mti_q;
  logic            p_msi_q;
  logic            p_mei;
  logic            wake_q;
  logic [XLEN-1:0] mip;
  logic [XLEN-1:0] en;
  logic [XLEN-1:0] sel_cause;
  logic [XLEN-1:0] cause_q, cause_d;
  logic [2:0]      hold_q, hold_d;
  logic            frozen_en;
  arb_state_e      state_q, state_d;

  irq_arbiter_sync_ff #(
    .Stages(SYNC_STAGES)
  ) u_eip_sync (
    .clk_i(i_clk),
    .rst_i(i_rst),
    .d_i  (i_eip),
    .q_o  (p_mei)
  );

  always_comb begin
    mip          = '0;
    mip[MEI_BIT] = p_mei;
    mip[MTI_BIT] = p_mti_q;
    mip[MSI_BIT] = p_msi_q;
  end

  assign en = mip & bus.mie;

  always_comb begin
    sel_cause = '0;
    if (en[MEI_BIT]) begin
      sel_cause = mk_cause(CAUSE_MEI);
    end else if (en[MSI_BIT]) begin
      sel_cause = mk_cause(CAUSE_MSI);
    end else if (en[MTI_BIT]) begin
      sel_cause = mk_cause(CAUSE_MTI);
    end
  end

  // Is the cause latched on entry to REQ still pending and enabled?
  always_comb begin
    frozen_en = 1'b0;
    case (cause_q[3:0])
      CAUSE_MEI: frozen_en = en[MEI_BIT];
      CAUSE_MSI: frozen_en = en[MSI_BIT];
      CAUSE_MTI: frozen_en = en[MTI_BIT];
      default:   frozen_en = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    hold_d  = hold_q;
    unique case (state_q)
      StIdle: begin
        if ((|en) && bus.mstatus_mie) begin
          state_d = StReq;
          cause_d = sel_cause;
        end
      end
      StReq: begin
        // Ack beats a simultaneous withdraw: the trap unit has already committed.
        if (bus.irq_ack) begin
          state_d = StHold;
          hold_d  = HoldLoad;
        end else if (!frozen_en || !bus.mstatus_mie) begin
          state_d = StIdle;
        end
      end
      StHold: begin
        hold_d = hold_q - 3'd1;
        if (hold_q <= 3'd1) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= StIdle;
      cause_q <= '0;
      hold_q  <= '0;
      p_mti_q <= 1'b0;
      p_msi_q <= 1'b0;
      wake_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      hold_q  <= hold_d;
      p_mti_q <= i_tip;
      p_msi_q <= i_sip;
      wake_q  <= |en;
    end
  end

  assign bus.irq_req   = (state_q == StReq);
  assign bus.irq_cause = cause_q;
  assign bus.mip       = mip;
  assign bus.wfi_wake  = wake_q;

endmodule

// File: tb/tb_irq_arbiter.sv
// Directed bench for irq_arbiter: a cycle model of the interrupt rules is compared every cycle,
// and hand-computed literals pin the key latencies and priority decisions.
module tb_irq_arbiter;
  import irq_arbiter_pkg::*;

  localparam int unsigned SyncStages = 2;
  localparam int unsigned HoldCycles = 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tip = 1'b0;
  logic sip = 1'b0;
  logic eip = 1'b0;

  int checks = 0;
  int errors = 0;

  irq_arbiter_if bus ();

  irq_arbiter #(
    .SYNC_STAGES(SyncStages),
    .HOLD_CYCLES(HoldCycles)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_tip(tip),
    .i_sip(sip),
    .i_eip(eip),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Model: pending levels, eip delay line, trap outstanding flag and remaining hold cycles.
  bit              m_mti;
  bit              m_msi;
  bit              m_eip_dly[$];
  bit              m_wake;
  bit              m_pend;
  int              m_hold;
  int              m_code;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_mei();
    return m_eip_dly[SyncStages-1];
  endfunction

  function automatic logic [31:0] exp_mip();
    logic [31:0] v;
    v     = '0;
    v[11] = m_mei();
    v[7]  = m_mti;
    v[3]  = m_msi;
    return v;
  endfunction

  task automatic model_reset();
    m_mti = 0;
    m_msi = 0;
    m_eip_dly.delete();
    for (int i = 0; i < SyncStages; i++) m_eip_dly.push_back(1'b0);
    m_wake = 0;
    m_pend = 0;
    m_hold = 0;
    m_code = 0;
  endtask

  task automatic model_step();
    bit e_mei, e_mti, e_msi, any, still;
    int sel;
    if (rst) begin
      model_reset();
      return;
    end
    e_mei = m_mei() && bus.mie[11];
    e_mti = m_mti && bus.mie[7];
    e_msi = m_msi && bus.mie[3];
    any   = e_mei || e_mti || e_msi;
    sel   = e_mei ? 11 : (e_msi ? 3 : 7);
    still = (m_code == 11 && e_mei) || (m_code == 3 && e_msi) || (m_code == 7 && e_mti);
    m_wake = any;
    if (m_pend) begin
      if (bus.irq_ack) begin
        m_pend = 0;
        m_hold = HoldCycles;
      end else if (!still || !bus.mstatus_mie) begin
        m_pend = 0;
      end
    end else if (m_hold > 0) begin
      m_hold--;
    end else if (any && bus.mstatus_mie) begin
      m_pend = 1;
      m_code = sel;
    end
    void'(m_eip_dly.pop_back());
    m_eip_dly.push_front(eip);
    m_mti = tip;
    m_msi = sip;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      model_step();
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (!rst) begin
        check("model_req", {31'd0, bus.irq_req}, {31'd0, m_pend});
        check("model_mip", bus.mip, exp_mip());
        check("model_wake", {31'd0, bus.wfi_wake}, {31'd0, m_wake});
        if (m_pend) check("model_cause", bus.irq_cause, 32'h8000_0000 | 32'(m_code));
      end
    end
  end

  task automatic at_edge();
    @(posedge clk);
    #3;
  endtask

  task automatic wait_req(input string name);
    int n;
    n = 0;
    while (bus.irq_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'd0, bus.irq_req}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    bus.irq_ack     = 1'b0;
    bus.mie         = '0;
    bus.mstatus_mie = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("rst_req", {31'd0, bus.irq_req}, 32'd0);
    check("rst_cause", bus.irq_cause, 32'd0);
    check("rst_mip", bus.mip, 32'd0);
    check("rst_wake", {31'd0, bus.wfi_wake}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // 1: timer interrupt, ack, one HOLD cycle, then re-request while tip stays high.
    @(negedge clk);
    bus.mie         = 32'h888;
    bus.mstatus_mie = 1'b1;
    @(negedge clk);
    tip = 1'b1;
    at_edge();
    check("t1_mip", bus.mip, 32'h080);
    check("t1_req_early", {31'd0, bus.irq_req}, 32'd0);
    at_edge();
    check("t1_req", {31'd0, bus.irq_req}, 32'd1);
    check("t1_cause", bus.irq_cause, 32'h8000_0007);
    @(negedge clk);
    @(negedge clk);
    bus.irq_ack = 1'b1;
    at_edge();
    check("t1_req_acked", {31'd0, bus.irq_req}, 32'd0);
    @(negedge clk);
    bus.irq_ack = 1'b0;
    at_edge();
    check("t1_hold", {31'd0, bus.irq_req}, 32'd0);
    at_edge();
    check("t1_rereq", {31'd0, bus.irq_req}, 32'd1);
    @(negedge clk);
    bus.irq_ack = 1'b1;
    tip         = 1'b0;
    @(negedge clk);
    bus.irq_ack = 1'b0;
    repeat (4) @(negedge clk);

    // 2: all three at once; MSI wins before MEI clears the synchronizer, MEI next.
    tip = 1'b1;
    sip = 1'b1;
    eip = 1'b1;
    at_edge();
    check("t2_mip_e1", bus.mip, 32'h088);
    at_edge();
    check("t2_req", {31'd0, bus.irq_req}, 32'd1);
    check("t2_cause_msi", bus.irq_cause, 32'h8000_0003);
    check("t2_mip_e2", bus.mip, 32'h888);
    @(negedge clk);
    bus.irq_ack = 1'b1;
    at_edge();
    @(negedge clk);
    bus.irq_ack = 1'b0;
    at_edge();
    check("t2_hold", {31'd0, bus.irq_req}, 32'd0);
    at_edge();
    check("t2_req2", {31'd0, bus.irq_req}, 32'd1);
    check("t2_cause_mei", bus.irq_cause, 32'h8000_000B);
    @(negedge clk);
    bus.irq_ack = 1'b1;
    tip         = 1'b0;
    sip         = 1'b0;
    eip         = 1'b0;
    @(negedge clk);
    bus.irq_ack = 1'b0;
    repeat (5) @(negedge clk);

    // 3: MEI arriving during REQ must not preempt the frozen timer cause.
    tip = 1'b1;
    wait_req("t3_req");
    check("t3_cause", bus.irq_cause, 32'h8000_0007);
    eip = 1'b1;
    for (int i = 0; i < 4; i++) begin
      at_edge();
      check("t3_cause_frozen", bus.irq_cause, 32'h8000_0007);
    end
    @(negedge clk);
    bus.irq_ack = 1'b1;
    tip         = 1'b0;
    eip         = 1'b0;
    at_edge();
    check("t3_acked", {31'd0, bus.irq_req}, 32'd0);
    @(negedge clk);
    bus.irq_ack = 1'b0;
    repeat (5) @(negedge clk);

    // 4: withdraw without ack, then ack coinciding with a withdraw (ack wins -> HOLD).
    tip = 1'b1;
    wait_req("t4_req");
    tip = 1'b0;
    at_edge();
    check("t4_still_req", {31'd0, bus.irq_req}, 32'd1);
    at_edge();
    check("t4_withdrawn", {31'd0, bus.irq_req}, 32'd0);
    @(negedge clk);
    tip = 1'b1;
    wait_req("t4_req2");
    bus.mie     = 32'h0;
    bus.irq_ack = 1'b1;
    at_edge();
    check("t4_ack_wd", {31'd0, bus.irq_req}, 32'd0);
    @(negedge clk);
    bus.mie     = 32'h888;
    bus.irq_ack = 1'b0;
    at_edge();
    check("t4_in_hold", {31'd0, bus.irq_req}, 32'd0);
    at_edge();
    check("t4_rereq", {31'd0, bus.irq_req}, 32'd1);
    check("t4_cause", bus.irq_cause, 32'h8000_0007);
    @(negedge clk);
    bus.irq_ack = 1'b1;
    tip         = 1'b0;
    @(negedge clk);
    bus.irq_ack = 1'b0;
    repeat (4) @(negedge clk);

    // 5: globally disabled: no request, but WFI wake one cycle after mip.
    bus.mstatus_mie = 1'b0;
    bus.mie         = 32'h080;
    tip             = 1'b1;
    at_edge();
    check("t5_mip", bus.mip, 32'h080);
    check("t5_wake_early", {31'd0, bus.wfi_wake}, 32'd0);
    at_edge();
    check("t5_wake", {31'd0, bus.wfi_wake}, 32'd1);
    repeat (3) at_edge();
    check("t5_no_req", {31'd0, bus.irq_req}, 32'd0);
    @(negedge clk);
    tip = 1'b0;
    repeat (3) @(negedge clk);
    bus.mstatus_mie = 1'b1;
    bus.mie         = 32'h888;

    // 6: asynchronous reset mid-REQ drops everything at once; request returns after release.
    tip = 1'b1;
    wait_req("t6_req");
    #1 rst = 1'b1;
    #1;
    check("t6_rst_req", {31'd0, bus.irq_req}, 32'd0);
    check("t6_rst_mip", bus.mip, 32'd0);
    check("t6_rst_wake", {31'd0, bus.wfi_wake}, 32'd0);
    check("t6_rst_cause", bus.irq_cause, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    at_edge();
    check("t6_rel_req", {31'd0, bus.irq_req}, 32'd0);
    check("t6_rel_mip", bus.mip, 32'h080);
    at_edge();
    check("t6_rel_req2", {31'd0, bus.irq_req}, 32'd1);
    check("t6_rel_cause", bus.irq_cause, 32'h8000_0007);
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
